// File: rtl/rv32_pkg.sv
// Shared RV32I definitions used by the write-back stage and the LSU:
// datapath width, load funct3 encodings and the write-back FSM states.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } wb_state_t;

endpackage

// File: rtl/rf_writeback_if.sv
// Execute-to-write-back handshake plus the data-memory read response.
// The execute/memory side is the master; the write-back stage is the slave.
interface rf_writeback_if;
    import rv32_pkg::*;

    logic            ex_valid;
    logic            ex_ready;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_result;
    logic            ex_is_load;
    logic [2:0]      ex_funct3;
    logic [1:0]      ex_addr_lo;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, ex_addr_lo,
        output mem_rvalid, mem_rdata,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, ex_addr_lo,
        input  mem_rvalid, mem_rdata,
        output ex_ready
    );

endinterface

// File: rtl/load_extend.sv
// Combinational load data alignment: picks the byte/half/word out of an
// aligned memory word, sign/zero extends it and flags illegal loads.
module load_extend
    import rv32_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Reserved funct3 codes and misaligned halves/words are reported as illegal.
    always_comb begin
        data    = '0;
        illegal = 1'b0;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'b0, byte_sel};
            F3_LH: begin
                data    = {{16{half_sel[15]}}, half_sel};
                illegal = addr_lo[0];
            end
            F3_LHU: begin
                data    = {16'b0, half_sel};
                illegal = addr_lo[0];
            end
            F3_LW: begin
                data    = rdata;
                illegal = (addr_lo != 2'd0);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rf_writeback.sv
// RV32I write-back stage: sole driver of the register-file write port,
// handling ALU results and one outstanding load at a time.
module rf_writeback
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    rf_writeback_if.slave   bus,
    output logic            write_en,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] write_data,
    output logic [XLEN-1:0] busy_mask,
    output logic            load_err
);

    wb_state_t       state;
    wb_state_t       next_state;
    logic            accept;
    logic            load_done;
    logic [4:0]      ld_rd;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_addr_lo;
    logic [XLEN-1:0] ext_data;
    logic            ext_illegal;
    logic [XLEN-1:0] rd_onehot;

    load_extend u_load_extend (
        .funct3  (ld_funct3),
        .addr_lo (ld_addr_lo),
        .rdata   (bus.mem_rdata),
        .data    (ext_data),
        .illegal (ext_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // ex_ready depends on state alone so execute never sees a combinational path.
    always_comb begin
        next_state   = state;
        bus.ex_ready = (state == IDLE);
        accept       = bus.ex_valid && (state == IDLE);
        load_done    = bus.mem_rvalid && (state == WAIT_LOAD);
        case (state)
            IDLE:      if (accept && bus.ex_is_load) next_state = WAIT_LOAD;
            WAIT_LOAD: if (bus.mem_rvalid)           next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    assign rd_onehot = {{(XLEN-1){1'b0}}, 1'b1} << bus.ex_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_rd      <= '0;
            ld_funct3  <= '0;
            ld_addr_lo <= '0;
        end else if (accept && bus.ex_is_load) begin
            ld_rd      <= bus.ex_rd;
            ld_funct3  <= bus.ex_funct3;
            ld_addr_lo <= bus.ex_addr_lo;
        end
    end

    // busy_mask stays up through the write cycle and is dropped on the following edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_en   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            load_err   <= 1'b0;
            busy_mask  <= '0;
        end else begin
            write_en <= 1'b0;
            load_err <= 1'b0;
            if (state == IDLE) begin
                busy_mask <= (accept && bus.ex_is_load && bus.ex_rd != 5'd0) ? rd_onehot : '0;
            end
            if (accept && !bus.ex_is_load) begin
                write_en   <= (bus.ex_rd != 5'd0);
                write_reg  <= bus.ex_rd;
                write_data <= bus.ex_result;
            end else if (load_done) begin
                if (ext_illegal) begin
                    load_err <= 1'b1;
                end else begin
                    write_en   <= (ld_rd != 5'd0);
                    write_reg  <= ld_rd;
                    write_data <= ext_data;
                end
            end
        end
    end

endmodule
